// File: rtl/gpio_lut_writer_pkg.sv
// ising_config: shared constants and types for the GPIO-to-LUT writer.
//   W_CLK_BIT        gpio_in bit carrying the host write strobe (w_clk)
//   DATA_MSB/LSB     gpio_in slice carrying the data byte
//   GADDR_MSB/LSB    gpio_in slice carrying the GPIO register address
//   LUT_ADDR_REG     GPIO register that carries LUT address bytes
//   LUT_DATA_REG     GPIO register that carries LUT data bytes
//   wr_state_e       byte-sequence FSM states
package ising_config;
  localparam int W_CLK_BIT = 24;
  localparam int DATA_MSB  = 23;
  localparam int DATA_LSB  = 16;
  localparam int GADDR_MSB = 15;
  localparam int GADDR_LSB = 0;

  localparam logic [15:0] LUT_ADDR_REG = 16'h0000;
  localparam logic [15:0] LUT_DATA_REG = 16'h0001;

  // A_HI/A_LO collect the two address bytes, D_HI/D_LO the two data bytes.
  typedef enum logic [1:0] {
    A_HI = 2'd0,
    A_LO = 2'd1,
    D_HI = 2'd2,
    D_LO = 2'd3
  } wr_state_e;
endpackage

// File: rtl/gpio_lut_writer_sync_edge.sv
// gpio_sync_edge: brings an asynchronous strobe plus its payload into the
// clk domain through a 2-flop synchronizer, then turns each rising edge of
// the strobe into a one-cycle event pulse.
//   clk, rst     clock, asynchronous active-low reset
//   strobe       asynchronous write strobe
//   payload      W-bit asynchronous payload qualified by strobe
//   ev           registered one-cycle pulse per strobe rising edge
//   payload_q    payload sampled through the same stages as ev
// The payload travels through the same number of flops as the strobe so
// the byte/address seen with ev is the one the host held while strobing.
module gpio_sync_edge #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         strobe,
  input  logic [W-1:0] payload,
  output logic         ev,
  output logic [W-1:0] payload_q
);
  logic         strobe_s1;
  logic         strobe_s2;
  logic         strobe_prev;
  logic [W-1:0] pay_s1;
  logic [W-1:0] pay_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strobe_s1   <= 1'b0;
      strobe_s2   <= 1'b0;
      strobe_prev <= 1'b0;
      pay_s1      <= '0;
      pay_s2      <= '0;
      ev          <= 1'b0;
      payload_q   <= '0;
    end else begin
      strobe_s1   <= strobe;
      strobe_s2   <= strobe_s1;
      strobe_prev <= strobe_s2;
      pay_s1      <= payload;
      pay_s2      <= pay_s1;
      // Edge, not level: a strobe held high for many cycles yields one event.
      ev          <= strobe_s2 & ~strobe_prev;
      payload_q   <= pay_s2;
    end
  end
endmodule

// File: rtl/gpio_lut_writer.sv
// gpio_lut_writer: assembles LUT writes from a byte-wide GPIO register
// interface. The host writes two address bytes (high first) to ADDR_REG and
// then two data bytes (high first) to DATA_REG; the second data byte commits
// one LUT write.
//   clk, rst      clock, asynchronous active-low reset
//   gpio_in       [15:0] GPIO address, [23:16] byte, [24] w_clk, rest unused
//   lut_wr_en     one-cycle LUT write strobe
//   lut_wr_addr   LUT write address, held until the next commit
//   lut_wr_data   LUT write data, held until the next commit
//   seq_err       sticky flag for an out-of-order byte; cleared by reset only
//   wr_count      commit counter saturating at 16'hFFFF, present only when
//                 GPIO_LUT_WRITER_CNT_EN is defined
// Handshake: there is no back-pressure; every strobed GPIO write is one
// event, and lut_wr_en is a fire-and-forget pulse the LUT must accept.
// Commit timing: lut_wr_en rises on the 4th clk edge after the first edge
// that samples w_clk high for the final data byte (2 sync flops, 1 edge
// register, 1 FSM update, then the output register).
module gpio_lut_writer
  import ising_config::*;
#(
  parameter logic [15:0] ADDR_REG   = LUT_ADDR_REG,
  parameter logic [15:0] DATA_REG   = LUT_DATA_REG,
  parameter int          LUT_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           gpio_in,
  output logic                  lut_wr_en,
  output logic [LUT_ADDR_W-1:0] lut_wr_addr,
  output logic [15:0]           lut_wr_data,
  output logic                  seq_err
`ifdef GPIO_LUT_WRITER_CNT_EN
  ,
  output logic [15:0]           wr_count
`endif
);
  logic        ev;
  logic [23:0] pay;
  logic [7:0]  byte_in;
  logic [15:0] gaddr;
  logic        hit_addr;
  logic        hit_data;
  logic        unused_bits;

  wr_state_e   state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_hi_q, data_hi_d;
  logic        err_set;
  logic        commit;

  logic                  commit_q;
  logic [LUT_ADDR_W-1:0] stage_addr_q;
  logic [15:0]           stage_data_q;

  assign unused_bits = ^gpio_in[31:25];

  gpio_sync_edge #(.W(24)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .strobe    (gpio_in[W_CLK_BIT]),
    .payload   (gpio_in[DATA_MSB:GADDR_LSB]),
    .ev        (ev),
    .payload_q (pay)
  );

  assign byte_in  = pay[DATA_MSB:DATA_LSB];
  assign gaddr    = pay[GADDR_MSB:GADDR_LSB];
  assign hit_addr = ev && (gaddr == ADDR_REG);
  assign hit_data = ev && (gaddr == DATA_REG) && (gaddr != ADDR_REG);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_hi_d = data_hi_q;
    err_set   = 1'b0;
    commit    = 1'b0;
    case (state_q)
      A_HI: begin
        if (hit_addr) begin
          addr_d[15:8] = byte_in;
          state_d      = A_LO;
        end else if (hit_data) begin
          err_set = 1'b1;
        end
      end
      A_LO: begin
        if (hit_addr) begin
          addr_d[7:0] = byte_in;
          state_d     = D_HI;
        end else if (hit_data) begin
          err_set = 1'b1;
        end
      end
      D_HI, D_LO: begin
        if (hit_data) begin
          if (state_q == D_HI) begin
            data_hi_d = byte_in;
            state_d   = D_LO;
          end else begin
            commit  = 1'b1;
            state_d = A_HI;
          end
        end else if (hit_addr) begin
          // A new address mid-data means the host restarted: treat the byte
          // as a fresh high address byte so the next write can complete it.
          err_set      = 1'b1;
          addr_d[15:8] = byte_in;
          state_d      = A_LO;
        end
      end
      default: state_d = A_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= A_HI;
      addr_q       <= '0;
      data_hi_q    <= '0;
      seq_err      <= 1'b0;
      commit_q     <= 1'b0;
      stage_addr_q <= '0;
      stage_data_q <= '0;
      lut_wr_en    <= 1'b0;
      lut_wr_addr  <= '0;
      lut_wr_data  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_hi_q <= data_hi_d;
      seq_err   <= seq_err | err_set;
      commit_q  <= commit;
      if (commit) begin
        // Plain truncation: the 16-bit address is two's complement but the
        // LUT index is just its low bits.
        stage_addr_q <= addr_q[LUT_ADDR_W-1:0];
        stage_data_q <= {data_hi_q, byte_in};
      end
      lut_wr_en <= commit_q;
      if (commit_q) begin
        lut_wr_addr <= stage_addr_q;
        lut_wr_data <= stage_data_q;
      end
    end
  end

`ifdef GPIO_LUT_WRITER_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= '0;
    end else if (commit_q && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_gpio_lut_writer.sv
module tb_gpio_lut_writer;
  localparam logic [15:0] A_REG = 16'h0000;
  localparam logic [15:0] D_REG = 16'h0001;

  logic        clk;
  logic        rst;
  logic [31:0] gpio_in;
  logic        lut_wr_en;
  logic [7:0]  lut_wr_addr;
  logic [15:0] lut_wr_data;
  logic        seq_err;
`ifdef GPIO_LUT_WRITER_CNT_EN
  logic [15:0] wr_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [23:0] exp_q[$];

  gpio_lut_writer dut (
    .clk         (clk),
    .rst         (rst),
    .gpio_in     (gpio_in),
    .lut_wr_en   (lut_wr_en),
    .lut_wr_addr (lut_wr_addr),
    .lut_wr_data (lut_wr_data),
    .seq_err     (seq_err)
`ifdef GPIO_LUT_WRITER_CNT_EN
    ,
    .wr_count    (wr_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_phase;
  logic [7:0]  m_ahi, m_alo, m_dhi;
  logic        m_err;
  logic [7:0]  m_last_a;
  logic [15:0] m_last_d;
  int          m_cnt;

  function automatic void model_reset();
    m_phase = 0; m_ahi = 0; m_alo = 0; m_dhi = 0; m_err = 0;
    m_last_a = 0; m_last_d = 0; m_cnt = 0;
  endfunction

  // Byte-sequence rules: two address bytes then two data bytes; a stray
  // data byte while collecting the address is dropped, a stray address byte
  // while collecting data restarts the address.
  function automatic void model_event(input logic [15:0] ga, input logic [7:0] b);
    if (ga == A_REG) begin
      if (m_phase == 0) begin m_ahi = b; m_phase = 1; end
      else if (m_phase == 1) begin m_alo = b; m_phase = 2; end
      else begin m_err = 1; m_ahi = b; m_phase = 1; end
    end else if (ga == D_REG) begin
      if (m_phase < 2) m_err = 1;
      else if (m_phase == 2) begin m_dhi = b; m_phase = 3; end
      else begin
        m_last_a = m_alo;
        m_last_d = {m_dhi, b};
        if (m_cnt < 65535) m_cnt++;
        exp_q.push_back({m_last_a, m_last_d});
        m_phase = 0;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic gpio_write(input logic [15:0] ga, input logic [7:0] b, input int hold);
    @(negedge clk);
    gpio_in = {7'($urandom), 1'b1, b, ga};
    repeat (hold) @(negedge clk);
    gpio_in[24] = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check("pending_before_reset", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    gpio_in = '0;
    #1;
    check("rst_en", 32'(lut_wr_en), 32'd0);
    check("rst_addr", 32'(lut_wr_addr), 32'd0);
    check("rst_data", 32'(lut_wr_data), 32'd0);
    check("rst_err", 32'(seq_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic        prev_en = 1'b0;
  logic [23:0] mon_e;
  always begin
    @(posedge clk);
    #1;
    if (rst && lut_wr_en) begin
      check("wr_en_single_cycle", 32'(prev_en), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_commit_addr", 32'(lut_wr_addr), 32'hDEAD_BEEF);
      end else begin
        mon_e = exp_q.pop_front();
        check("commit_addr", 32'(lut_wr_addr), 32'(mon_e[23:16]));
        check("commit_data", 32'(lut_wr_data), 32'(mon_e[15:0]));
      end
    end
    prev_en = lut_wr_en;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst_before;
    logic [15:0] ga;
    logic [7:0]  b;
    int          hold;
    logic        exp_err;
    logic        exp_commit;
    logic [7:0]  exp_a;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [15:0] ga, input logic [7:0] b,
                              input int hold, input logic e, input logic c,
                              input logic [7:0] a, input logic [15:0] d);
    vec_t v;
    v.rst_before = r; v.ga = ga; v.b = b; v.hold = hold;
    v.exp_err = e; v.exp_commit = c; v.exp_a = a; v.exp_d = d;
    vecs.push_back(v);
  endfunction

  logic [7:0]  last_a;
  logic [15:0] last_d;
  int          cnt;

  initial begin
    rst = 1'b0;
    gpio_in = '0;
    #1;
    check("init_en", 32'(lut_wr_en), 32'd0);
    check("init_addr", 32'(lut_wr_addr), 32'd0);
    check("init_data", 32'(lut_wr_data), 32'd0);
    check("init_err", 32'(seq_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // basic write, then negative-address truncation, then 0x7F boundary
    add(1, A_REG, 8'h00, 1, 0, 0, 8'h00, 16'h0000);
    add(0, A_REG, 8'h05, 2, 0, 0, 8'h00, 16'h0000);
    add(0, D_REG, 8'h12, 1, 0, 0, 8'h00, 16'h0000);
    add(0, D_REG, 8'h34, 3, 0, 1, 8'h05, 16'h1234);
    add(0, A_REG, 8'hFF, 1, 0, 0, 8'h05, 16'h1234);
    add(0, A_REG, 8'h80, 1, 0, 0, 8'h05, 16'h1234);
    add(0, D_REG, 8'h80, 1, 0, 0, 8'h05, 16'h1234);
    add(0, D_REG, 8'h00, 1, 0, 1, 8'h80, 16'h8000);
    add(0, A_REG, 8'h00, 1, 0, 0, 8'h80, 16'h8000);
    add(0, A_REG, 8'h7F, 1, 0, 0, 8'h80, 16'h8000);
    add(0, D_REG, 8'h00, 1, 0, 0, 8'h80, 16'h8000);
    add(0, D_REG, 8'h01, 1, 0, 1, 8'h7F, 16'h0001);
    // data before any address
    add(1, D_REG, 8'hAA, 1, 1, 0, 8'h00, 16'h0000);
    add(0, A_REG, 8'h00, 1, 1, 0, 8'h00, 16'h0000);
    add(0, A_REG, 8'h01, 1, 1, 0, 8'h00, 16'h0000);
    add(0, D_REG, 8'h00, 1, 1, 0, 8'h00, 16'h0000);
    add(0, D_REG, 8'h02, 1, 1, 1, 8'h01, 16'h0002);
    // address restart in the middle of data
    add(1, A_REG, 8'h00, 1, 0, 0, 8'h00, 16'h0000);
    add(0, A_REG, 8'h03, 1, 0, 0, 8'h00, 16'h0000);
    add(0, D_REG, 8'h11, 1, 0, 0, 8'h00, 16'h0000);
    add(0, A_REG, 8'h00, 1, 1, 0, 8'h00, 16'h0000);
    add(0, A_REG, 8'h07, 1, 1, 0, 8'h00, 16'h0000);
    add(0, D_REG, 8'h22, 1, 1, 0, 8'h00, 16'h0000);
    add(0, D_REG, 8'h33, 1, 1, 1, 8'h07, 16'h2233);
    // long strobe, foreign register writes interleaved
    add(1, A_REG,    8'h00, 10, 0, 0, 8'h00, 16'h0000);
    add(0, 16'h0042, 8'h55, 1,  0, 0, 8'h00, 16'h0000);
    add(0, A_REG,    8'h0A, 1,  0, 0, 8'h00, 16'h0000);
    add(0, 16'h0042, 8'h66, 4,  0, 0, 8'h00, 16'h0000);
    add(0, D_REG,    8'hBE, 1,  0, 0, 8'h00, 16'h0000);
    add(0, 16'h0042, 8'h77, 1,  0, 0, 8'h00, 16'h0000);
    add(0, D_REG,    8'hEF, 2,  0, 1, 8'h0A, 16'hBEEF);

    last_a = 0; last_d = 0; cnt = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) begin
        do_reset();
        last_a = 0; last_d = 0; cnt = 0;
      end
      if (vecs[i].exp_commit) begin
        exp_q.push_back({vecs[i].exp_a, vecs[i].exp_d});
        cnt++;
      end
      gpio_write(vecs[i].ga, vecs[i].b, vecs[i].hold);
      check($sformatf("tbl%0d_err", i), 32'(seq_err), 32'(vecs[i].exp_err));
      check($sformatf("tbl%0d_addr", i), 32'(lut_wr_addr), 32'(vecs[i].exp_a));
      check($sformatf("tbl%0d_data", i), 32'(lut_wr_data), 32'(vecs[i].exp_d));
`ifdef GPIO_LUT_WRITER_CNT_EN
      check($sformatf("tbl%0d_count", i), 32'(wr_count), 32'(cnt));
`endif
    end

    // reset in the middle of a sequence: partial bytes discarded
    gpio_write(A_REG, 8'h00, 1);
    gpio_write(A_REG, 8'h09, 1);
    gpio_write(D_REG, 8'h55, 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_en", 32'(lut_wr_en), 32'd0);
    check("async_rst_addr", 32'(lut_wr_addr), 32'd0);
    check("async_rst_data", 32'(lut_wr_data), 32'd0);
    check("async_rst_err", 32'(seq_err), 32'd0);
`ifdef GPIO_LUT_WRITER_CNT_EN
    check("async_rst_count", 32'(wr_count), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
    gpio_write(D_REG, 8'h66, 1);
    check("midrst_err", 32'(seq_err), 32'd1);
    check("midrst_addr", 32'(lut_wr_addr), 32'd0);
    check("midrst_data", 32'(lut_wr_data), 32'd0);
    check("midrst_no_commit", 32'(exp_q.size()), 32'd0);

    // commit latency measured from the first edge sampling w_clk high
    do_reset();
    gpio_write(A_REG, 8'h00, 1);
    gpio_write(A_REG, 8'h01, 1);
    gpio_write(D_REG, 8'h00, 1);
    exp_q.push_back({8'h01, 16'h0077});
    @(negedge clk);
    gpio_in = {7'h0, 1'b1, 8'h77, D_REG};
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency_edge%0d", k), 32'(lut_wr_en), (k == 4) ? 32'd1 : 32'd0);
      if (k == 1) gpio_in[24] = 1'b0;
    end
    repeat (3) @(negedge clk);

    // randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 250; n++) begin
      logic [15:0] ga;
      logic [7:0]  b;
      int          sel;
      if (n == 125) begin
        do_reset();
        model_reset();
      end
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      ga = A_REG;
      else if (sel < 8) ga = D_REG;
      else              ga = 16'($urandom_range(2, 16'hFFFF));
      b = 8'($urandom);
      model_event(ga, b);
      gpio_write(ga, b, int'($urandom_range(1, 4)));
      if (n % 25 == 24) begin
        check($sformatf("rnd%0d_err", n), 32'(seq_err), 32'(m_err));
        check($sformatf("rnd%0d_addr", n), 32'(lut_wr_addr), 32'(m_last_a));
        check($sformatf("rnd%0d_data", n), 32'(lut_wr_data), 32'(m_last_d));
`ifdef GPIO_LUT_WRITER_CNT_EN
        check($sformatf("rnd%0d_count", n), 32'(wr_count), 32'(m_cnt));
`endif
      end
    end

    repeat (10) @(negedge clk);
    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
